// File: rtl/key_pulser.sv
// key_pulser: per-key 2-flop synchronizer, debounce and press/release FSM for the
// four active-low pushbuttons; keys selected by REPEAT_MASK auto-repeat while held.

module key_pulser_lane #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter int unsigned CNT_W           = 25
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_n_i,
    output logic strobe_o,
    output logic held_o
);
    typedef enum logic [2:0] {
        ST_LOCK, ST_IDLE, ST_PRESS_CHK, ST_DOWN, ST_REPEAT, ST_REL_CHK
    } state_e;

    localparam logic [CNT_W-1:0] DEB_T = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DLY_T = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_T = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             s;
    state_e           state_q, state_d;
    // One counter serves both roles: debounce count in LOCK/PRESS_CHK/REL_CHK,
    // repeat timer in DOWN/REPEAT. They are never needed at the same time.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ret_rep_q, ret_rep_d;  // REL_CHK bounce returns to REPEAT (1) or DOWN (0)
    logic             strobe_q, strobe_d;
    logic             held_q, held_d;

    assign s        = sync_q[1];
    assign strobe_o = strobe_q;
    assign held_o   = held_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q    <= 2'b11;
            state_q   <= ST_LOCK;
            cnt_q     <= '0;
            ret_rep_q <= 1'b0;
            strobe_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_n_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ret_rep_q <= ret_rep_d;
            strobe_q  <= strobe_d;
            held_q    <= held_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ret_rep_d = ret_rep_q;
        unique case (state_q)
            ST_LOCK: begin
                if (!s) begin
                    cnt_d = '0;
                end else if (cnt_q >= DEB_T) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_IDLE: begin
                if (!s) begin
                    state_d = ST_PRESS_CHK;
                    cnt_d   = ONE;
                end
            end
            ST_PRESS_CHK: begin
                if (s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_T) begin
                    state_d = ST_DOWN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_DOWN: begin
                if (s) begin
                    state_d   = ST_REL_CHK;
                    cnt_d     = ONE;
                    ret_rep_d = 1'b0;
                end else if (cnt_q < DLY_T) begin
                    cnt_d = cnt_q + ONE;
                end else if (REPEAT_EN) begin
                    state_d = ST_REPEAT;
                    cnt_d   = '0;
                end
            end
            ST_REPEAT: begin
                if (s) begin
                    state_d   = ST_REL_CHK;
                    cnt_d     = ONE;
                    ret_rep_d = 1'b1;
                end else if (cnt_q >= PER_T) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_REL_CHK: begin
                if (!s) begin
                    state_d = ret_rep_q ? ST_REPEAT : ST_DOWN;
                    cnt_d   = '0;
                end else if (cnt_q >= DEB_T) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = ST_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // A REPEAT->REPEAT step with the timer cleared is a period expiry; bounce
    // returns into REPEAT come from REL_CHK and so never strobe.
    always_comb begin
        strobe_d = 1'b0;
        unique case (state_q)
            ST_PRESS_CHK: strobe_d = (state_d == ST_DOWN);
            ST_DOWN:      strobe_d = (state_d == ST_REPEAT);
            ST_REPEAT:    strobe_d = (state_d == ST_REPEAT) && (cnt_d == '0);
            default:      strobe_d = 1'b0;
        endcase
        held_d = (state_d == ST_DOWN) || (state_d == ST_REPEAT) || (state_d == ST_REL_CHK);
    end
endmodule

module key_pulser #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter logic [3:0]  REPEAT_MASK     = 4'b0100,
    parameter int unsigned CNT_W           = 25
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [3:0] KEY,
    output logic       key0_pressed,
    output logic       key1_pressed,
    output logic       key2_pressed,
    output logic       key3_pressed,
    output logic [3:0] key_held
);
    logic [3:0] strobe;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_pulser_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (REPEAT_MASK[i]),
            .CNT_W          (CNT_W)
        ) u_lane (
            .clk_i   (CLOCK_50),
            .rst_n_i (reset_n),
            .key_n_i (KEY[i]),
            .strobe_o(strobe[i]),
            .held_o  (key_held[i])
        );
    end

    assign key0_pressed = strobe[0];
    assign key1_pressed = strobe[1];
    assign key2_pressed = strobe[2];
    assign key3_pressed = strobe[3];
endmodule

// File: tb/tb_key_pulser.sv
// Bench for key_pulser: directed scenarios plus randomized key traffic, all
// compared against a run-length based reference model.

module tb_key_pulser;
    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;
    localparam logic [3:0] MASK = 4'b0100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key = 4'hF;
    logic       k0, k1, k2, k3;
    logic [3:0] held;
    logic [3:0] str;
    assign str = {k3, k2, k1, k0};

    int n_cmp = 0;
    int n_bad = 0;

    key_pulser #(
        .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER),
        .REPEAT_MASK(MASK), .CNT_W(8)
    ) dut (
        .CLOCK_50(clk), .reset_n(rst_n), .KEY(key),
        .key0_pressed(k0), .key1_pressed(k1), .key2_pressed(k2), .key3_pressed(k3),
        .key_held(held)
    );

    always #5 clk = ~clk;

    // Reference model: tracks the length of the current run of equal
    // synchronized samples and applies the accept/release/repeat rules to it.
    logic [3:0] m_k1, m_k2;
    logic [3:0] exp_str, exp_held;
    bit         m_locked [4];
    bit         m_held   [4];
    bit         m_prev   [4];
    bit         m_rep    [4];
    int         m_run    [4];
    longint     m_anchor [4];
    longint     cyc = 0;
    bit         m_s;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k1 = 4'hF; m_k2 = 4'hF; exp_str = 4'h0; exp_held = 4'h0;
            for (int i = 0; i < 4; i++) begin
                m_locked[i] = 1'b1; m_held[i] = 1'b0; m_prev[i] = 1'b1;
                m_rep[i] = 1'b0; m_run[i] = 0; m_anchor[i] = 0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 4; i++) begin
                m_s = m_k2[i];
                m_run[i] = (m_s == m_prev[i]) ? m_run[i] + 1 : 1;
                m_prev[i] = m_s;
                exp_str[i] = 1'b0;
                if (m_locked[i]) begin
                    if (m_s && m_run[i] == DEB + 1) m_locked[i] = 1'b0;
                end else if (!m_held[i]) begin
                    if (!m_s && m_run[i] == DEB + 1) begin
                        m_held[i] = 1'b1; exp_str[i] = 1'b1;
                        m_anchor[i] = cyc; m_rep[i] = 1'b0;
                    end
                end else if (m_s) begin
                    if (m_run[i] == DEB + 1) m_held[i] = 1'b0;
                end else if (m_run[i] == 1) begin
                    m_anchor[i] = cyc;
                end else if (MASK[i] && (cyc - m_anchor[i]) == longint'(m_rep[i] ? PER : DLY)) begin
                    exp_str[i] = 1'b1; m_anchor[i] = cyc; m_rep[i] = 1'b1;
                end
                exp_held[i] = m_held[i];
            end
            m_k2 = m_k1;
            m_k1 = key;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; key = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (str !== 4'h0 || held !== 4'h0) begin
                n_bad++;
                $display("FAIL reset_out got str=%b held=%b want 0000/0000", str, held);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (str !== exp_str || held !== exp_held) begin
                n_bad++;
                $display("FAIL reset_model k=%0d got str=%b held=%b want %b/%b", k, str, held, exp_str, exp_held);
            end
        end
    endtask

    task automatic test_press();
        key[1] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n_cmp++;
            if (k1 !== (k == 6) || held[1] !== (k >= 6)) begin
                n_bad++;
                $display("FAIL press_k1 k=%0d got str=%b held=%b want %b/%b", k, k1, held[1], k == 6, k >= 6);
            end
            n_cmp++;
            if (str !== exp_str || held !== exp_held) begin
                n_bad++;
                $display("FAIL press_model k=%0d got str=%b held=%b want %b/%b", k, str, held, exp_str, exp_held);
            end
        end
        key[1] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            n_cmp++;
            if (k1 !== 1'b0 || held[1] !== (j < 6)) begin
                n_bad++;
                $display("FAIL press_release j=%0d got str=%b held=%b want 0/%b", j, k1, held[1], j < 6);
            end
        end
    endtask

    task automatic test_bounce();
        int lv [5] = '{0, 1, 0, 1, 1};
        int ln [5] = '{3, 2, 3, 10, 4};
        for (int p = 0; p < 5; p++) begin
            key[0] = lv[p][0];
            for (int k = 0; k < ln[p]; k++) begin
                @(negedge clk);
                n_cmp++;
                if (k0 !== 1'b0 || held[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bounce_k0 p=%0d got str=%b held=%b want 0/0", p, k0, held[0]);
                end
                n_cmp++;
                if (str !== exp_str || held !== exp_held) begin
                    n_bad++;
                    $display("FAIL bounce_model p=%0d got str=%b held=%b want %b/%b", p, str, held, exp_str, exp_held);
                end
            end
        end
    endtask

    task automatic test_repeat();
        bit e;
        key[2] = 1'b0;
        for (int k = 0; k < 38; k++) begin
            @(negedge clk);
            e = (k == 6) || (k >= 16 && (k - 16) % 3 == 0);
            n_cmp++;
            if (k2 !== e || held[2] !== (k >= 6)) begin
                n_bad++;
                $display("FAIL repeat_k2 k=%0d got str=%b held=%b want %b/%b", k, k2, held[2], e, k >= 6);
            end
        end
        key[2] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            n_cmp++;
            if (k2 !== 1'b0 || held[2] !== (j < 6)) begin
                n_bad++;
                $display("FAIL repeat_release j=%0d got str=%b held=%b want 0/%b", j, k2, held[2], j < 6);
            end
            n_cmp++;
            if (str !== exp_str || held !== exp_held) begin
                n_bad++;
                $display("FAIL repeat_model j=%0d got str=%b held=%b want %b/%b", j, str, held, exp_str, exp_held);
            end
        end
    endtask

    task automatic test_lock();
        @(negedge clk);
        rst_n = 1'b0; key = 4'b0111;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n_cmp++;
            if (k3 !== 1'b0 || held[3] !== 1'b0) begin
                n_bad++;
                $display("FAIL lock_k3 k=%0d got str=%b held=%b want 0/0", k, k3, held[3]);
            end
            n_cmp++;
            if (str !== exp_str || held !== exp_held) begin
                n_bad++;
                $display("FAIL lock_model k=%0d got str=%b held=%b want %b/%b", k, str, held, exp_str, exp_held);
            end
        end
        key[3] = 1'b1;
        repeat (10) @(negedge clk);
        key[3] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            n_cmp++;
            if (k3 !== (k == 6) || held[3] !== (k >= 6)) begin
                n_bad++;
                $display("FAIL lock_repress k=%0d got str=%b held=%b want %b/%b", k, k3, held[3], k == 6, k >= 6);
            end
        end
        key[3] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_glitch();
        key[1] = 1'b0;
        repeat (10) @(negedge clk);
        key[1] = 1'b1;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (k == 1) key[1] = 1'b0;
            n_cmp++;
            if (k1 !== 1'b0 || held[1] !== 1'b1) begin
                n_bad++;
                $display("FAIL glitch_k1 k=%0d got str=%b held=%b want 0/1", k, k1, held[1]);
            end
            n_cmp++;
            if (str !== exp_str || held !== exp_held) begin
                n_bad++;
                $display("FAIL glitch_model k=%0d got str=%b held=%b want %b/%b", k, str, held, exp_str, exp_held);
            end
        end
        key[1] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        key = 4'b0101;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (k1 !== (k == 6) || k3 !== (k == 6)) begin
                n_bad++;
                $display("FAIL simul k=%0d got k1=%b k3=%b want %b/%b", k, k1, k3, k == 6, k == 6);
            end
        end
        key = 4'hF;
        repeat (10) @(negedge clk);
        key[2] = 1'b0;
        repeat (21) @(negedge clk);
        n_cmp++;
        if (held[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre got held2=%b want 1", held[2]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (str !== 4'h0 || held !== 4'h0) begin
            n_bad++;
            $display("FAIL rst_async got str=%b held=%b want 0000/0000", str, held);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n_cmp++;
            if (k2 !== 1'b0 || held[2] !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_lock k=%0d got str=%b held=%b want 0/0", k, k2, held[2]);
            end
        end
        key[2] = 1'b1;
        repeat (10) @(negedge clk);
        key[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (k2 !== (k == 6)) begin
                n_bad++;
                $display("FAIL rst_repress k=%0d got str=%b want %b", k, k2, k == 6);
            end
        end
        key[2] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random();
        int rem [4] = '{0, 0, 0, 0};
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_cmp++;
            if (str !== exp_str || held !== exp_held) begin
                n_bad++;
                $display("FAIL rand_model c=%0d got str=%b held=%b want %b/%b", c, str, held, exp_str, exp_held);
            end
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (rem[i] == 0) begin
                    key[i] = ~key[i];
                    rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DEB + 1, 40))
                                                        : int'($urandom_range(1, DEB + 3));
                end else begin
                    rem[i]--;
                end
            end
        end
        rst_n = 1'b1; key = 4'hF;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_repeat();
        test_lock();
        test_glitch();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/key_pulser.md
Name: key_pulser

Overview:
Front-end conditioner for the four raw active-low pushbuttons (KEY[3:0]). It produces the single-cycle `key0_pressed`..`key3_pressed` strobes that the clock/alarm state machine consumes. Per key, it provides a 2-flop synchronizer, a debounce counter and a press/release state machine. Keys enabled in REPEAT_MASK also auto-repeat while held, so the increment key steps time fields continuously.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples needed to accept a press or release (20 ms at 50 MHz).
- REPEAT_DELAY, 25000000, cycles from the initial press pulse to the first auto-repeat pulse (0.5 s).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (0.2 s).
- REPEAT_MASK, 4'b0100, bit i=1 enables auto-repeat for key i (only key2 by default).
- CNT_W, 25, width of the per-key counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- KEY  in  4  raw pushbuttons, 0 = pressed, asynchronous to CLOCK_50
- key0_pressed  out  1  one-cycle press strobe, key 0
- key1_pressed  out  1  one-cycle press strobe, key 1
- key2_pressed  out  1  one-cycle press/repeat strobe, key 2
- key3_pressed  out  1  one-cycle press strobe, key 3
- key_held  out  4  debounced pressed level per key

Behaviour:
- Clocking and reset: one clock, CLOCK_50; reset is asynchronous and active-low (`reset_n`).
- Reset values:
  - all `keyN_pressed` = 0; `key_held` = 4'b0000.
  - synchronizer flops = 1 (released); counters = 0; every key state = LOCK.
- Synchronizer: 2 flops per key. Only the second flop (`s`) feeds logic. Raw-to-`s` latency is 2 cycles.
- All outputs are registered. Keys are fully independent; no priority or mutual exclusion.
- Per-key states: LOCK, IDLE, PRESS_CHK, DOWN, REPEAT, RELEASE_CHK.
- LOCK (after reset):
  - count consecutive cycles with `s`=1; any `s`=0 clears the count.
  - on reaching DEBOUNCE_CYCLES, go to IDLE.
  - no strobe and no held level is ever produced in LOCK, so a key held through reset is ignored until it is released.
- IDLE: `s`=0 -> PRESS_CHK with count=1.
- PRESS_CHK:
  - `s`=1 -> IDLE, count cleared (bounce, no strobe).
  - `s`=0 -> count++.
  - when count reaches DEBOUNCE_CYCLES -> DOWN; strobe high for exactly the first cycle in DOWN.
  - Clean press latency: strobe is high 2+DEBOUNCE_CYCLES cycles after the first edge that samples KEY low.
- DOWN:
  - repeat counter runs from 0.
  - if REPEAT_MASK[i] and the counter reaches REPEAT_DELAY -> REPEAT, with a one-cycle strobe.
  - `s`=1 -> RELEASE_CHK (return target = DOWN).
- REPEAT:
  - strobe every REPEAT_PERIOD cycles while `s`=0.
  - `s`=1 -> RELEASE_CHK (return target = REPEAT).
- RELEASE_CHK:
  - count consecutive `s`=1; reaching DEBOUNCE_CYCLES -> IDLE (no strobe on release).
  - `s`=0 before that -> back to the return target, with the repeat counter restarted from 0 and no strobe.
- `key_held[i]` = 1 in DOWN, REPEAT and RELEASE_CHK; otherwise 0.
- A strobe is never wider than one cycle. Minimum strobe spacing is min(REPEAT_DELAY, REPEAT_PERIOD).
- Counters saturate at their terminal count and never wrap.
- `reset_n` asserted mid-press or mid-repeat: outputs drop to 0 immediately (asynchronously) and the key re-enters LOCK.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_MASK=4'b0100.
1. Release `reset_n` with KEY=1111 for 8 cycles, then drive KEY[1]=0 and hold 40 cycles -> `key1_pressed` high exactly once, 6 cycles after the first low sample; `key_held[1]`=1 from that cycle on; no further strobes.
2. KEY[0] low 3 cycles, high 2, low 3, then high -> `key0_pressed` never asserts; `key_held[0]` stays 0.
3. Hold KEY[2]=0 for 30 cycles after a clean press -> `key2_pressed` at t0, t0+10, t0+13, t0+16, ...; after release, `key_held[2]` falls after 4+2 stable-high cycles with no strobe.
4. KEY[3]=0 while `reset_n`=0, held 50 cycles after reset release -> no `key3_pressed` and `key_held[3]`=0; release 10 cycles, press again -> one strobe at 6-cycle latency.
5. In DOWN, a 2-cycle high glitch on KEY[1] -> no extra strobe; `key_held[1]` stays 1 throughout.
6. KEY[1] and KEY[3] fall on the same edge -> `key1_pressed` and `key3_pressed` strobe in the same cycle. Then assert `reset_n`=0 during a key2 repeat -> all outputs 0 within that cycle, and no strobe until the key is released and pressed again.
